// File: rtl/button_hold_repeat_if.sv
// Button conditioner bundle: raw button in, debounced level and event strobes out.
interface button_hold_repeat_if;
  logic btn;
  logic level;
  logic pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic release_pulse;

  modport master (
    output btn,
    input  level,
    input  pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn,
    output level,
    output pulse,
    output long_pulse,
    output repeat_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_hold_repeat.sv
// Synchronises and debounces one raw button, then emits press / long-press / auto-repeat /
// release strobes from a hold-timer FSM. Every output is a flop; btn never reaches one directly.
module button_hold_repeat #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned LONG_CYCLES     = 5000000,
  parameter int unsigned REPEAT_CYCLES   = 1000000,
  parameter int unsigned CNT_W           = 24
) (
  input logic                  clk,
  input logic                  reset,
  button_hold_repeat_if.slave  bus_io
);

  localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StRepeat} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   flip;
  logic                   rise;
  logic                   fall;

  state_e                 state_q;
  logic [CNT_W-1:0]       hcnt_q;
  logic                   pulse_q;
  logic                   long_q;
  logic                   repeat_q;
  logic                   release_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Level flips only after the synced input has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (sync_s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DebLast) begin
      level_d = sync_s;
      dcnt_d  = '0;
      flip    = 1'b1;
    end else begin
      dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  assign rise = flip & sync_s;
  assign fall = flip & ~sync_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus_io.btn};
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
    end
  end

  // Strobes are registered on the same edge the debounced level changes; release outranks
  // any hold threshold reached on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      pulse_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      pulse_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            pulse_q <= 1'b1;
            hcnt_q  <= '0;
            state_q <= StPressed;
          end
        end
        StPressed: begin
          if (fall) begin
            release_q <= 1'b1;
            hcnt_q    <= '0;
            state_q   <= StIdle;
          end else if (hcnt_q == LongLast) begin
            long_q  <= 1'b1;
            hcnt_q  <= '0;
            state_q <= StRepeat;
          end else begin
            hcnt_q <= hcnt_q + CNT_W'(1);
          end
        end
        StRepeat: begin
          if (fall) begin
            release_q <= 1'b1;
            hcnt_q    <= '0;
            state_q   <= StIdle;
          end else if (hcnt_q == RepeatLast) begin
            repeat_q <= 1'b1;
            hcnt_q   <= '0;
          end else begin
            hcnt_q <= hcnt_q + CNT_W'(1);
          end
        end
        default: begin
          hcnt_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.level         = level_q;
  assign bus_io.pulse         = pulse_q;
  assign bus_io.long_pulse    = long_q;
  assign bus_io.repeat_pulse  = repeat_q;
  assign bus_io.release_pulse = release_q;

endmodule

// File: tb/tb_button_hold_repeat.sv
// Directed bench for button_hold_repeat: an edge-count model of debounce and hold timing is
// checked every cycle, and per-scenario strobe timings are pinned against literal edge numbers.
module tb_button_hold_repeat;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic clk;
  logic reset;
  button_hold_repeat_if bus ();

  button_hold_repeat #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP),
    .CNT_W           (24)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: s is the button as seen SYNC edges late; level follows a streak count.
  int   t = 0;
  int   base = 0;
  int   hist[$];
  int   streak;
  logic m_level;
  logic held;
  int   press_t;
  logic e_p, e_l, e_r, e_rel;
  int   pulse_log[$], long_log[$], rep_log[$], rel_log[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    string gs, es;
    logic  ok;
    ok = (got.size() == exp.size());
    if (ok) for (int i = 0; i < got.size(); i++) if (got[i] != exp[i]) ok = 1'b0;
    gs = "";
    es = "";
    foreach (got[i]) gs = $sformatf("%s %0d", gs, got[i]);
    foreach (exp[i]) es = $sformatf("%s %0d", es, exp[i]);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got={%s } expected={%s }", name, gs, es);
    end
  endtask

  // Compare process: advance the model one edge, then check all outputs 1 time unit later.
  initial begin : monitor
    logic       b, r, s, flip;
    int         el;
    logic [4:0] got, expv;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    streak  = 0;
    m_level = 1'b0;
    held    = 1'b0;
    press_t = 0;
    forever begin
      @(posedge clk);
      b = bus.btn;
      r = reset;
      #1;
      e_p = 1'b0; e_l = 1'b0; e_r = 1'b0; e_rel = 1'b0;
      if (r) begin
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(0);
        streak  = 0;
        m_level = 1'b0;
        held    = 1'b0;
      end else begin
        s = hist.pop_front() != 0;
        hist.push_back(int'(b));
        flip = 1'b0;
        if (s != m_level) streak++;
        else streak = 0;
        if (streak == DEB) begin
          m_level = s;
          streak  = 0;
          flip    = 1'b1;
        end
        if (flip && m_level) begin
          e_p = 1'b1; press_t = t; held = 1'b1;
        end else if (flip && held) begin
          e_rel = 1'b1; held = 1'b0;
        end else if (held) begin
          el = t - press_t;
          if (el == LONG) e_l = 1'b1;
          else if (el > LONG && (el - LONG) % REP == 0) e_r = 1'b1;
        end
      end
      got  = {bus.level, bus.pulse, bus.long_pulse, bus.repeat_pulse, bus.release_pulse};
      expv = {m_level, e_p, e_l, e_r, e_rel};
      total++;
      if (got !== expv) begin
        bad++;
        $display("FAIL outputs edge=%0d got=%b expected=%b (level,pulse,long,repeat,release)",
                 t - base, got, expv);
      end
      if (bus.pulse === 1'b1)         pulse_log.push_back(t - base);
      if (bus.long_pulse === 1'b1)    long_log.push_back(t - base);
      if (bus.repeat_pulse === 1'b1)  rep_log.push_back(t - base);
      if (bus.release_pulse === 1'b1) rel_log.push_back(t - base);
      t++;
    end
  end

  // Next posedge becomes relative edge 0.
  task automatic start();
    @(negedge clk);
    base = t;
    pulse_log.delete();
    long_log.delete();
    rep_log.delete();
    rel_log.delete();
  endtask

  task automatic drive(input logic v, input int n);
    bus.btn = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int none[$];
    none.delete();
    reset   = 1'b1;
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(bus.level), 0);
    chk("reset_pulse", int'(bus.pulse), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: short press, released before long-press
    start();
    drive(1'b1, 12);
    drive(1'b0, 15);
    chk_q("t1_pulse", pulse_log, '{5});
    chk_q("t1_long", long_log, none);
    chk_q("t1_release", rel_log, '{17});

    // 2: glitches shorter than the debounce window
    start();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    drive(1'b0, 6);
    chk("t2_strobes", pulse_log.size() + long_log.size() + rep_log.size() + rel_log.size(), 0);

    // 3: long hold with repeats; release lands on a repeat slot and wins
    start();
    drive(1'b1, 60);
    drive(1'b0, 15);
    chk_q("t3_pulse", pulse_log, '{5});
    chk_q("t3_long", long_log, '{25});
    chk_q("t3_repeat", rep_log, '{33, 41, 49, 57});
    chk_q("t3_release", rel_log, '{65});

    // 4: debounced fall coincides with the long-press threshold
    start();
    drive(1'b1, 20);
    drive(1'b0, 40);
    chk_q("t4_release", rel_log, '{25});
    chk_q("t4_long", long_log, none);
    chk_q("t4_repeat", rep_log, none);

    // 5: reset while held, button still down afterwards
    start();
    drive(1'b1, 30);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_level_in_reset", int'(bus.level), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32);
    drive(1'b0, 15);
    chk_q("t5_pulse", pulse_log, '{5, 37});
    chk_q("t5_long", long_log, '{25, 57});
    chk_q("t5_repeat", rep_log, '{65});
    chk_q("t5_release", rel_log, '{69});

    // 6: bounce every cycle, then settle pressed
    start();
    for (int k = 0; k < 10; k++) begin
      bus.btn = (k % 2 == 0);
      @(negedge clk);
    end
    drive(1'b1, 10);
    drive(1'b0, 15);
    chk_q("t6_pulse", pulse_log, '{15});
    chk_q("t6_release", rel_log, '{25});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
